// File: rtl/decode_pkg.sv
// Shared types and constants for the decode instruction queue.
package decode_pkg;

    localparam int unsigned ILEN_DEF = 16;
    localparam int unsigned XLEN_DEF = 32;

    localparam logic [ILEN_DEF-1:0] NOP_INSTR = 16'hFFFF;

    typedef struct packed {
        logic [ILEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
    } instr_entry_t;

    // Which source drives the control-unit outputs this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_SELF,
        SRC_HEAD,
        SRC_BYPASS
    } src_sel_e;

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction FIFO with flush; a push into a full FIFO only lands
// when a pop frees the slot in the same cycle, otherwise it is reported as dropped.
module instr_fifo
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = instr_entry_t,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CW     = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          drop
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          empty;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never reset; pointers and count alone define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/decode_instr_queue.sv
// Decode-stage instruction queue: FIFO of fetched instructions, a
// micro-op self slot, and a same-cycle bypass to the control unit.
module decode_instr_queue
    import decode_pkg::*;
#(
    parameter int unsigned ILEN  = ILEN_DEF,
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic [ILEN-1:0]          instr_i,
    input  logic                     instr_en_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [ILEN-1:0]          self_instr_i,
    input  logic                     self_instr_en_i,
    output logic [ILEN-1:0]          cu_instr_o,
    output logic [XLEN-1:0]          cu_pc_o,
    output logic                     cu_valid_o,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    src_sel_e      sel;
    entry_t        head;
    entry_t        self_q;
    logic          self_valid_q;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_drop;
    logic          consume;
    logic          push;
    logic          pop;
    logic          overflow_q;

    instr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata ('{instr: instr_i, pc: pc_i}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .drop  (fifo_drop)
    );

    always_comb begin
        sel = SRC_NONE;
        if (self_valid_q)
            sel = SRC_SELF;
        else if (fifo_count != '0)
            sel = SRC_HEAD;
        else if (instr_en_i)
            sel = SRC_BYPASS;
    end

    always_comb begin
        cu_instr_o = ILEN'(NOP_INSTR);
        cu_pc_o    = '0;
        cu_valid_o = 1'b0;
        case (sel)
            SRC_SELF: begin
                cu_instr_o = self_q.instr;
                cu_pc_o    = self_q.pc;
                cu_valid_o = 1'b1;
            end
            SRC_HEAD: begin
                cu_instr_o = head.instr;
                cu_pc_o    = head.pc;
                cu_valid_o = 1'b1;
            end
            SRC_BYPASS: begin
                cu_instr_o = instr_i;
                cu_pc_o    = pc_i;
                cu_valid_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign consume = cu_valid_o & ~stall_i & ~flush_i;
    assign pop     = consume & (sel == SRC_HEAD);
    // A bypassed fetch consumed this cycle never enters storage.
    assign push    = instr_en_i & ~flush_i & ~((sel == SRC_BYPASS) & consume);

    // A new micro-op wins over clearing, so chains reload back to back.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            self_valid_q <= 1'b0;
        end else if (consume) begin
            if (self_instr_en_i) begin
                self_valid_q <= 1'b1;
                self_q       <= '{instr: self_instr_i, pc: cu_pc_o};
            end else if (sel == SRC_SELF) begin
                self_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            overflow_q <= 1'b0;
        else
            overflow_q <= fifo_drop;
    end

    assign count_o       = fifo_count;
    assign full_o        = fifo_full;
    assign almost_full_o = (fifo_count >= CW'(DEPTH - 1));
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_decode_instr_queue.sv
// Bench for decode_instr_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_decode_instr_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [15:0] instr_i = '0;
    logic        instr_en_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [15:0] self_instr_i = '0;
    logic        self_instr_en_i = 1'b0;
    logic [15:0] cu_instr_o;
    logic [31:0] cu_pc_o;
    logic        cu_valid_o;
    logic        full_o;
    logic        almost_full_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    decode_instr_queue #(
        .ILEN  (16),
        .XLEN  (32),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .instr_i         (instr_i),
        .instr_en_i      (instr_en_i),
        .pc_i            (pc_i),
        .self_instr_i    (self_instr_i),
        .self_instr_en_i (self_instr_en_i),
        .cu_instr_o      (cu_instr_o),
        .cu_pc_o         (cu_pc_o),
        .cu_valid_o      (cu_valid_o),
        .full_o          (full_o),
        .almost_full_o   (almost_full_o),
        .count_o         (count_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    bit   m_sv;
    ent_t m_self;
    bit   m_ovf;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model for the current inputs, then advance the model.
    task automatic cyc();
        int   src;
        ent_t e;
        bit   consume;
        bit   full;
        bit   pop;
        bit   byp;
        #1;
        src = 0;
        e.instr = 16'hFFFF;
        e.pc = 0;
        if (m_sv) begin src = 1; e = m_self; end
        else if (q.size() > 0) begin src = 2; e = q[0]; end
        else if (instr_en_i) begin src = 3; e.instr = instr_i; e.pc = pc_i; end

        chk("valid", cu_valid_o, (src != 0));
        chk("instr", cu_instr_o, e.instr);
        chk("pc", cu_pc_o, e.pc);
        chk("count", count_o, q.size());
        chk("full", full_o, (q.size() == DEPTH));
        chk("almost_full", almost_full_o, (q.size() >= DEPTH - 1));
        chk("overflow", overflow_o, m_ovf);

        consume = (src != 0) && !stall_i && !flush_i;
        if (rst_i || flush_i) begin
            q.delete();
            m_sv  = 0;
            m_ovf = 0;
        end else begin
            full = (q.size() == DEPTH);
            pop  = consume && (src == 2);
            byp  = consume && (src == 3);
            if (consume && self_instr_en_i) begin
                m_sv = 1;
                m_self.instr = self_instr_i;
                m_self.pc = e.pc;
            end else if (consume && src == 1) begin
                m_sv = 0;
            end
            if (pop) void'(q.pop_front());
            m_ovf = 0;
            if (instr_en_i && !byp) begin
                if (!full || pop) q.push_back('{instr: instr_i, pc: pc_i});
                else m_ovf = 1;
            end
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit f, input bit e,
                         input logic [15:0] i, input logic [31:0] p,
                         input bit se, input logic [15:0] si);
        rst_i = r; stall_i = s; flush_i = f; instr_en_i = e;
        instr_i = i; pc_i = p; self_instr_en_i = se; self_instr_i = si;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0);
        cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v;
        q.delete(); m_sv = 0; m_ovf = 0;
        drive(1, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0);
        @(negedge clk);

        // Reset held: everything idle.
        cyc();
        @(negedge clk);
        idle_cycle();
        drive(0, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0);
        cyc();
        chk("rst_count", count_o, 0);
        chk("rst_valid", cu_valid_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_ovf", overflow_o, 0);
        @(negedge clk);

        // Bypass on empty queue.
        drive(0, 0, 0, 1, 16'h1C08, 32'h100, 0, 16'h0);
        cyc();
        chk("byp_instr", cu_instr_o, 16'h1C08);
        chk("byp_pc", cu_pc_o, 32'h100);
        chk("byp_valid", cu_valid_o, 1);
        chk("byp_count", count_o, 0);
        @(negedge clk);
        idle_cycle();

        // Stalled fetches overfill the queue.
        for (int k = 0; k < 5; k++) begin
            v = 16'hA001 + 16'(k);
            drive(0, 1, 0, 1, v, 32'h200 + 2 * k, 0, 16'h0);
            cyc();
            if (k == 4) begin
                chk("ovf_count", count_o, 4);
                chk("ovf_full", full_o, 1);
                chk("ovf_pre", overflow_o, 0);
            end
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0);
            cyc();
            v = 16'hA001 + 16'(k);
            chk("ovf_order", cu_instr_o, v);
            chk("ovf_pulse", overflow_o, (k == 0));
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0);
        cyc();
        chk("ovf_lost", cu_valid_o, 0);
        @(negedge clk);

        // Micro-op chain.
        drive(0, 1, 0, 1, 16'hB500, 32'h400, 0, 16'h0); cyc(); @(negedge clk);
        drive(0, 1, 0, 1, 16'hC001, 32'h404, 0, 16'h0); cyc(); @(negedge clk);
        drive(0, 0, 0, 0, 16'h0, 32'h0, 1, 16'hB501); cyc();
        chk("chain0", cu_instr_o, 16'hB500); chk("chain0_pc", cu_pc_o, 32'h400);
        @(negedge clk);
        drive(0, 0, 0, 0, 16'h0, 32'h0, 1, 16'hB502); cyc();
        chk("chain1", cu_instr_o, 16'hB501); chk("chain1_pc", cu_pc_o, 32'h400);
        @(negedge clk);
        drive(0, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0); cyc();
        chk("chain2", cu_instr_o, 16'hB502); chk("chain2_pc", cu_pc_o, 32'h400);
        @(negedge clk);
        cyc();
        chk("chain3", cu_instr_o, 16'hC001); chk("chain3_pc", cu_pc_o, 32'h404);
        @(negedge clk);
        idle_cycle();

        // Flush with three queued entries and a pending self slot.
        for (int k = 0; k < 3; k++) begin
            v = 16'hD001 + 16'(k);
            drive(0, 1, 0, 1, v, 32'h500 + 2 * k, 0, 16'h0);
            cyc(); @(negedge clk);
        end
        drive(0, 0, 0, 1, 16'hD004, 32'h506, 1, 16'hE001); cyc(); @(negedge clk);
        drive(0, 0, 1, 1, 16'hD005, 32'h508, 0, 16'h0); cyc();
        chk("fl_pre_count", count_o, 3);
        chk("fl_pre_self", cu_instr_o, 16'hE001);
        @(negedge clk);
        drive(0, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0); cyc();
        chk("fl_count", count_o, 0);
        chk("fl_valid", cu_valid_o, 0);
        chk("fl_nop", cu_instr_o, 16'hFFFF);
        chk("fl_ovf", overflow_o, 0);
        @(negedge clk);

        // Full queue streaming across pointer wrap.
        for (int k = 0; k < 4; k++) begin
            v = 16'hF000 + 16'(k);
            drive(0, 1, 0, 1, v, 32'h600 + 2 * k, 0, 16'h0);
            cyc(); @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            v = 16'hF004 + 16'(k);
            drive(0, 0, 0, 1, v, 32'h608 + 2 * k, 0, 16'h0);
            cyc();
            v = 16'hF000 + 16'(k);
            chk("wrap_count", count_o, 4);
            chk("wrap_order", cu_instr_o, v);
            chk("wrap_ovf", overflow_o, 0);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) idle_cycle();

        // Reset mid-chain with a full queue.
        for (int k = 0; k < 4; k++) begin
            v = 16'h7000 + 16'(k);
            drive(0, 1, 0, 1, v, 32'h700 + 2 * k, 0, 16'h0);
            cyc(); @(negedge clk);
        end
        drive(0, 0, 0, 1, 16'h7004, 32'h708, 1, 16'h7100); cyc(); @(negedge clk);
        drive(1, 0, 0, 1, 16'h7005, 32'h70A, 1, 16'h7101); cyc();
        chk("rc_pre_full", full_o, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 16'h0, 32'h0, 0, 16'h0); cyc();
        chk("rc_count", count_o, 0);
        chk("rc_valid", cu_valid_o, 0);
        chk("rc_ovf", overflow_o, 0);
        chk("rc_full", full_o, 0);
        @(negedge clk);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                  16'($urandom), $urandom, ($urandom_range(0, 2) == 0), 16'($urandom));
            cyc();
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_instr_queue.md
DECODE_INSTR_QUEUE -- requirements
Module: decode_instr_queue

Interface
REQ-001 Parameters SHALL be: ILEN, default 16, instruction width; XLEN, default 32, PC width; DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 clk_i  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 stall_i  input  1  decode stall; high means the presented instruction is not consumed this cycle.
REQ-005 flush_i  input  1  branch-taken flush; discards all queued and pending instructions.
REQ-006 instr_i  input  ILEN  fetched instruction.
REQ-007 instr_en_i  input  1  instr_i/pc_i valid this cycle.
REQ-008 pc_i  input  XLEN  program counter of instr_i.
REQ-009 self_instr_i  input  ILEN  follow-on micro-instruction from the control unit.
REQ-010 self_instr_en_i  input  1  self_instr_i valid; follows the currently presented instruction.
REQ-011 cu_instr_o  output  ILEN  instruction presented to the control unit.
REQ-012 cu_pc_o  output  XLEN  PC belonging to cu_instr_o.
REQ-013 cu_valid_o  output  1  cu_instr_o holds a real instruction.
REQ-014 full_o  output  1  count == DEPTH.
REQ-015 almost_full_o  output  1  count >= DEPTH-1; fetch throttle.
REQ-016 count_o  output  $clog2(DEPTH)+1  queued entries, excluding self slot.
REQ-017 overflow_o  output  1  one-cycle pulse: an instruction was dropped because the queue was full.

Function
REQ-018 Presented source SHALL be chosen combinationally, priority: self slot if valid; else queue head if count>0; else instr_i if instr_en_i (bypass); else NOP.
REQ-019 When no source is valid, cu_instr_o SHALL be NOP_INSTR (16'hFFFF), cu_pc_o 0, cu_valid_o 0.
REQ-020 consume = cu_valid_o & ~stall_i & ~flush_i; consuming the self slot clears it, consuming the head pops it.
REQ-021 instr_i SHALL be enqueued (with pc_i) when instr_en_i & ~flush_i & ~(bypass selected & consume).
REQ-022 Bypass consumed same cycle SHALL yield zero queue latency; otherwise latency is queue position plus pending self slot.
REQ-023 Enqueue when count==DEPTH SHALL succeed only if a pop occurs the same cycle; otherwise instr_i is dropped, count unchanged, overflow_o pulses next cycle.
REQ-024 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo DEPTH.
REQ-025 self_instr_en_i SHALL load the self slot only when consume is high; self_instr_i loads with PC = cu_pc_o of the consuming instruction.
REQ-026 self_instr_en_i while stall_i or flush_i is high SHALL be ignored.
REQ-027 A self slot consumed in the same cycle a new self_instr_en_i arrives SHALL be reloaded, not cleared (micro-op chains).
REQ-028 flush_i SHALL, next cycle, empty the queue, clear the self slot, zero pointers/count; flush overrides every push, pop and self load that cycle.
REQ-029 While stall_i is high and not flushing, queue contents, self slot and presented instruction SHALL remain unchanged except for REQ-021 pushes.

Reset
REQ-030 rst_i SHALL zero read/write pointers, count, self-slot valid and overflow flag; queue storage need not be cleared.
REQ-031 During and one cycle after reset: cu_valid_o 0 unless bypass active, full_o 0, almost_full_o 0 (DEPTH>=2), count_o 0, overflow_o 0.
REQ-032 Reset SHALL take precedence over flush_i, stall_i and all enables, including mid-micro-op chain.

Structure
REQ-033 decode_pkg SHALL hold ILEN/XLEN defaults, NOP_INSTR, and typedef instr_entry_t {instr, pc}.
REQ-034 Storage SHALL be one sub-module, instr_fifo (DEPTH x instr_entry_t, push/pop/flush, count); selection and self slot stay in decode_instr_queue.

Verification
REQ-035 Empty queue, no stall, instr_en_i with 16'h1C08/pc 0x100 -> cu_instr_o=16'h1C08, cu_pc_o=0x100, cu_valid_o=1 same cycle, count_o stays 0.
REQ-036 stall_i high 5 cycles, 5 fetches, DEPTH=4 -> count_o=4, full_o=1, overflow_o pulses once; after release instructions emerge in order, 5th lost.
REQ-037 Self chain: consume 16'hB500 with self_instr_en_i=1 (16'hB501), next cycle again (16'hB502) -> order B500,B501,B502 then queue head; all carry B500's PC.
REQ-038 Queue holding 3 entries plus self slot, flush_i pulse -> next cycle count_o=0, cu_valid_o=0, cu_instr_o=16'hFFFF; same-cycle instr_en_i dropped, overflow_o stays 0.
REQ-039 Full queue, no stall, instr_en_i each cycle for 10 cycles -> count_o stays 4, no overflow, outputs in fetch order across pointer wrap.
REQ-040 rst_i asserted mid-chain with queue full -> next cycle count_o=0, self slot empty, overflow_o=0, full_o=0.
